rev_gate_sequencer: RTL and testbench

- Controller that runs a stored program of reversible gates (NOT, CNOT, Toffoli, Fredkin) on a WIDTH-bit state register, one gate per clock.
- Runs the program forward, or in reverse to uncompute it. Every gate is self-inverse, so reversing the gate order undoes the run exactly.
- Generalises our single Toffoli/Fredkin gate into a sequenced, shared datapath for multi-gate reversible circuits.

---
 rtl/rev_seq_pkg.sv | 37 +++
 rtl/rev_gate_apply.sv | 66 ++++++
 rtl/rev_gate_sequencer.sv | 133 +++++++++++++
 tb/tb_rev_gate_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rev_seq_pkg.sv
// Shared definitions for the reversible gate sequencer: opcodes,
// instruction field layout and FSM state encoding.
package rev_seq_pkg;

    localparam logic [1:0] OP_NOT  = 2'b00;
    localparam logic [1:0] OP_CNOT = 2'b01;
    localparam logic [1:0] OP_TOFF = 2'b10;
    localparam logic [1:0] OP_FRED = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Instruction layout, MSB first: {op[1:0], a, b, c}
    function automatic int instr_w(input int idx_w);
        return 2 + 3 * idx_w;
    endfunction

    function automatic int op_lsb(input int idx_w);
        return 3 * idx_w;
    endfunction

    function automatic int a_lsb(input int idx_w);
        return 2 * idx_w;
    endfunction

    function automatic int b_lsb(input int idx_w);
        return idx_w;
    endfunction

    function automatic int c_lsb(input int idx_w);
        return 0 * idx_w;
    endfunction

endpackage

// File: rtl/rev_gate_apply.sv
// Combinational reversible gate datapath: applies one instruction to the
// state vector; illegal instructions pass the state through unchanged.
module rev_gate_apply
    import rev_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IDX_W   = $clog2(WIDTH),
    parameter int INSTR_W = 2 + 3 * IDX_W
) (
    input  logic [WIDTH-1:0]   state_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [WIDTH-1:0]   state_o,
    output logic               illegal_o
);

    logic [1:0]       op;
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
    logic [IDX_W-1:0] c;
    logic             a_ok;
    logic             b_ok;
    logic             c_ok;
    logic             all_ok;
    logic             distinct;

    assign op = instr_i[op_lsb(IDX_W) +: 2];
    assign a  = instr_i[a_lsb(IDX_W) +: IDX_W];
    assign b  = instr_i[b_lsb(IDX_W) +: IDX_W];
    assign c  = instr_i[c_lsb(IDX_W) +: IDX_W];

    assign a_ok     = 32'(a) < WIDTH;
    assign b_ok     = 32'(b) < WIDTH;
    assign c_ok     = 32'(c) < WIDTH;
    assign all_ok   = a_ok && b_ok && c_ok;
    assign distinct = (a != b) && (a != c) && (b != c);

    always_comb begin
        state_o   = state_i;
        illegal_o = 1'b0;
        unique case (op)
            OP_NOT: begin
                illegal_o = !c_ok;
                if (!illegal_o)
                    state_o[c] = ~state_i[c];
            end
            OP_CNOT: begin
                illegal_o = !(a_ok && c_ok) || (a == c);
                if (!illegal_o)
                    state_o[c] = state_i[c] ^ state_i[a];
            end
            OP_TOFF: begin
                illegal_o = !all_ok || !distinct;
                if (!illegal_o)
                    state_o[c] = state_i[c] ^ (state_i[a] & state_i[b]);
            end
            OP_FRED: begin
                illegal_o = !all_ok || !distinct;
                if (!illegal_o && state_i[a]) begin
                    state_o[b] = state_i[c];
                    state_o[c] = state_i[b];
                end
            end
        endcase
    end

endmodule

// File: rtl/rev_gate_sequencer.sv
// Sequencer running a stored reversible-gate program forward or in reverse.
// Optional RSEQ_SINGLE_STEP_EN adds a step input gating instruction issue.
module rev_gate_sequencer
    import rev_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int PC_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef RSEQ_SINGLE_STEP_EN
    input  logic                     step,
`endif
    input  logic                     prog_we,
    input  logic [PC_W-1:0]          prog_addr,
    input  logic [2+3*IDX_W-1:0]     prog_data,
    input  logic [PC_W:0]            len,
    input  logic                     start,
    input  logic                     dir,
    input  logic [WIDTH-1:0]         state_in,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         state_out,
    output logic                     illegal
);

    localparam int INSTR_W = instr_w(IDX_W);
    localparam logic [PC_W:0] LEN_MAX = (PC_W+1)'(DEPTH);

    fsm_e               fsm_q, fsm_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W:0]      rem_q, rem_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   state_q, state_d;
    logic               ill_q, ill_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic [PC_W:0]      len_c;
    logic [INSTR_W-1:0] instr;
    logic [WIDTH-1:0]   gate_state;
    logic               gate_ill;
    logic               adv;

`ifdef RSEQ_SINGLE_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    assign len_c = (len > LEN_MAX) ? LEN_MAX : len;
    assign instr = mem_q[pc_q];

    rev_gate_apply #(
        .WIDTH   (WIDTH),
        .IDX_W   (IDX_W),
        .INSTR_W (INSTR_W)
    ) u_apply (
        .state_i   (state_q),
        .instr_i   (instr),
        .state_o   (gate_state),
        .illegal_o (gate_ill)
    );

    always_comb begin
        fsm_d   = fsm_q;
        pc_d    = pc_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        state_d = state_q;
        ill_d   = ill_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = state_in;
                    ill_d   = 1'b0;
                    dir_d   = dir;
                    rem_d   = len_c;
                    pc_d    = dir ? PC_W'(len_c - 1'b1) : '0;
                    fsm_d   = (len_c == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (adv) begin
                    state_d = gate_state;
                    ill_d   = ill_q | gate_ill;
                    rem_d   = rem_q - 1'b1;
                    // pc holds on the final instruction so it never wraps
                    if (rem_q == (PC_W+1)'(1))
                        fsm_d = ST_DONE;
                    else
                        pc_d = dir_q ? pc_q - 1'b1 : pc_q + 1'b1;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            state_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            state_q <= state_d;
            ill_q   <= ill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fsm_q == ST_IDLE && prog_we)
            mem_q[prog_addr] <= prog_data;
    end

    assign busy      = (fsm_q == ST_RUN);
    assign done      = (fsm_q == ST_DONE);
    assign state_out = state_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_rev_gate_sequencer.sv
// Self-checking bench for rev_gate_sequencer: directed cases plus
// randomized programs checked against a behavioural gate model.
module tb_rev_gate_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [10:0] prog_data;
    logic [4:0]  len;
    logic        start;
    logic        dir;
    logic [7:0]  state_in;
    logic        busy;
    logic        done;
    logic [7:0]  state_out;
    logic        illegal;

    logic [10:0] prog [16];
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  fwd_x;

    rev_gate_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .len       (len),
        .start     (start),
        .dir       (dir),
        .state_in  (state_in),
        .busy      (busy),
        .done      (done),
        .state_out (state_out),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ins(input int op, input int a,
                                        input int b, input int c);
        logic [1:0] o = 2'(op);
        logic [2:0] aa = 3'(a);
        logic [2:0] bb = 3'(b);
        logic [2:0] cc = 3'(c);
        return {o, aa, bb, cc};
    endfunction

    // Gate semantics straight from the opcode table
    function automatic logic [7:0] mgate(input logic [7:0] s_in,
                                         input logic [10:0] w,
                                         output bit ill);
        logic [7:0] s = s_in;
        int op = int'(w[10:9]);
        int a = int'(w[8:6]);
        int b = int'(w[5:3]);
        int c = int'(w[2:0]);
        bit t;
        ill = 0;
        case (op)
            0: s[c] = ~s[c];
            1: if (a == c) ill = 1;
               else if (s[a]) s[c] = ~s[c];
            2: if (a == b || a == c || b == c) ill = 1;
               else if (s[a] && s[b]) s[c] = ~s[c];
            default:
               if (a == b || a == c || b == c) ill = 1;
               else if (s[a]) begin
                   t = s[b];
                   s[b] = s[c];
                   s[c] = t;
               end
        endcase
        return s;
    endfunction

    task automatic wr(input int addr, input logic [10:0] data);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = 4'(addr);
        prog_data = data;
        prog[addr] = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_run(input int n, input bit d, input logic [7:0] sin,
                          input string tag, input bit disturb,
                          input bit wws, input int wa,
                          input logic [10:0] wd);
        int nn = (n > 16) ? 16 : n;
        logic [7:0] exp = sin;
        bit il = 0;
        bit ik;
        int idx;
        int cyc = 0;
        if (wws) prog[wa] = wd;
        for (int k = 0; k < nn; k++) begin
            idx = d ? nn - 1 - k : k;
            exp = mgate(exp, prog[idx], ik);
            il |= ik;
        end
        @(negedge clk);
        start = 1'b1;
        len = 5'(n);
        dir = d;
        state_in = sin;
        if (wws) begin
            prog_we = 1'b1;
            prog_addr = 4'(wa);
            prog_data = wd;
        end
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b0;
        len = 5'($urandom);
        dir = 1'($urandom);
        state_in = 8'($urandom);
        while (busy && cyc < 40) begin
            cyc++;
            if (disturb && nn >= 4 && cyc == 1) begin
                start = 1'b1;
                prog_we = 1'b1;
                prog_addr = 4'($urandom);
                prog_data = 11'($urandom);
            end
            if (cyc == 2) begin
                start = 1'b0;
                prog_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        prog_we = 1'b0;
        check({tag, "_cycles"}, cyc, nn);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_in_done"}, busy, 0);
        check({tag, "_state"}, state_out, exp);
        check({tag, "_illegal"}, illegal, il);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        len = '0;
        start = 1'b0;
        dir = 1'b0;
        state_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", state_out, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++)
            wr(i, ins(0, 0, 0, i % 8));

        // Toffoli forward
        wr(0, ins(2, 0, 1, 2));
        do_run(1, 0, 8'h03, "t1", 0, 0, 0, '0);
        check("t1_const", state_out, 8'h07);

        // Fredkin with control high then low
        wr(0, ins(3, 7, 0, 1));
        do_run(1, 0, 8'h81, "t2a", 0, 0, 0, '0);
        check("t2a_const", state_out, 8'h82);
        do_run(1, 0, 8'h01, "t2b", 0, 0, 0, '0);
        check("t2b_const", state_out, 8'h01);

        // Round trip
        wr(0, ins(0, 0, 0, 5));
        wr(1, ins(1, 0, 0, 3));
        wr(2, ins(2, 1, 3, 6));
        wr(3, ins(3, 6, 2, 4));
        do_run(4, 0, 8'hA5, "t3f", 0, 0, 0, '0);
        fwd_x = state_out;
        do_run(4, 1, fwd_x, "t3r", 0, 0, 0, '0);
        check("t3_roundtrip", state_out, 8'hA5);

        // Empty run, then a run with ignored start/prog_we pulses
        do_run(0, 0, 8'h5A, "t4z", 0, 0, 0, '0);
        check("t4z_const", state_out, 8'h5A);
        do_run(4, 0, 8'hA5, "t4d", 1, 0, 0, '0);
        check("t4d_same", state_out, fwd_x);
        do_run(4, 1, fwd_x, "t4r", 0, 0, 0, '0);
        check("t4r_const", state_out, 8'hA5);

        // Illegal instruction, then clearing on next start
        wr(0, ins(2, 2, 3, 2));
        do_run(1, 0, 8'h0C, "t5a", 0, 0, 0, '0);
        check("t5a_const", state_out, 8'h0C);
        check("t5a_ill", illegal, 1);
        do_run(1, 0, 8'h0C, "t5b", 0, 1, 0, ins(0, 0, 0, 0));
        check("t5b_const", state_out, 8'h0D);
        check("t5b_ill", illegal, 0);

        // Reset mid-run
        wr(0, ins(0, 0, 0, 5));
        @(negedge clk);
        start = 1'b1;
        len = 5'd4;
        dir = 1'b0;
        state_in = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_state", state_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_no_done", done, 0);
        do_run(4, 0, 8'hA5, "t6", 0, 0, 0, '0);
        check("t6_const", state_out, fwd_x);

        // Randomized programs
        for (int it = 0; it < 40; it++) begin
            int nw = int'($urandom_range(0, 3));
            for (int j = 0; j < nw; j++)
                wr(int'($urandom_range(0, 15)), 11'($urandom));
            do_run(int'($urandom_range(0, 20)), 1'($urandom),
                   8'($urandom), "rnd", 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 15)), 11'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
